// File: rtl/ctrl_decode_stage.sv
// ID stage for the RV32IM pipeline: decodes the instruction into a control bundle held in the
// ID/EX register, and sequences multi-cycle MUL/DIV/REM occupancy of EX with a front-end stall.
module ctrl_decode_stage #(
   parameter int unsigned ALU_OP_W    = 5,
   parameter int unsigned MDU_LATENCY = 4,
   parameter int unsigned CNT_W       = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [31:0]         i_instr,
   input  logic                i_valid,
   input  logic                i_stall,
   input  logic                i_flush,
   output logic                o_valid,
   output logic                o_illegal,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic [1:0]          o_op1_sel,
   output logic                o_op2_sel,
   output logic [1:0]          o_wb_sel,
   output logic [2:0]          o_lsu_op,
   output logic                o_rd_wren,
   output logic                o_mem_rden,
   output logic                o_mem_wren,
   output logic                o_branch,
   output logic                o_jmp,
   output logic                o_br_unsign,
   output logic                o_stall_req,
   output logic                o_mdu_done
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic                valid;
      logic                illegal;
      logic [ALU_OP_W-1:0] alu_op;
      logic [1:0]          op1_sel;
      logic                op2_sel;
      logic [1:0]          wb_sel;
      logic [2:0]          lsu_op;
      logic                rd_wren;
      logic                mem_rden;
      logic                mem_wren;
      logic                branch;
      logic                jmp;
      logic                br_unsign;
   } bundle_t;

   typedef enum logic {IDLE, MDU_RUN} state_t;

   bundle_t          dec, bundle_q, bundle_d;
   logic             dec_mdu, dec_bad;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_d;
   logic             accept;

   logic [6:0] opc, f7;
   logic [2:0] f3;

   assign opc = i_instr[6:0];
   assign f3  = i_instr[14:12];
   assign f7  = i_instr[31:25];

   // Base ALU code for a funct3; alt selects sub/sra
   function automatic logic [4:0] alu_code(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'b000:  alu_code = alt ? 5'd1 : 5'd0;
         3'b001:  alu_code = 5'd2;
         3'b010:  alu_code = 5'd3;
         3'b011:  alu_code = 5'd4;
         3'b100:  alu_code = 5'd5;
         3'b101:  alu_code = alt ? 5'd7 : 5'd6;
         3'b110:  alu_code = 5'd8;
         default: alu_code = 5'd9;
      endcase
   endfunction

   always_comb begin : decode
      dec       = '0;
      dec_mdu   = 1'b0;
      dec_bad   = 1'b0;
      dec.valid = 1'b1;
      case (opc)
         OPC_LUI: begin
            dec.op1_sel = 2'd2; dec.op2_sel = 1'b1; dec.rd_wren = 1'b1;
         end
         OPC_AUIPC: begin
            dec.op1_sel = 2'd1; dec.op2_sel = 1'b1; dec.rd_wren = 1'b1;
         end
         OPC_JAL: begin
            dec.op1_sel = 2'd1; dec.op2_sel = 1'b1; dec.wb_sel = 2'd2;
            dec.jmp = 1'b1; dec.rd_wren = 1'b1;
         end
         OPC_JALR: begin
            dec_bad     = (f3 != 3'b000);
            dec.op2_sel = 1'b1; dec.wb_sel = 2'd2; dec.jmp = 1'b1; dec.rd_wren = 1'b1;
         end
         OPC_BRANCH: begin
            dec_bad       = (f3[2:1] == 2'b01);
            dec.op1_sel   = 2'd1; dec.op2_sel = 1'b1; dec.branch = 1'b1;
            dec.br_unsign = f3[1];
         end
         OPC_LOAD: begin
            dec_bad      = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            dec.op2_sel  = 1'b1; dec.wb_sel = 2'd1; dec.mem_rden = 1'b1;
            dec.rd_wren  = 1'b1; dec.lsu_op = f3;
         end
         OPC_STORE: begin
            dec_bad      = f3[2] || (f3 == 3'b011);
            dec.op2_sel  = 1'b1; dec.mem_wren = 1'b1; dec.lsu_op = f3;
         end
         OPC_OPIMM: begin
            if ((f3 == 3'b001 || f3 == 3'b101) && f7 != 7'b0000000 && f7 != 7'b0100000)
               dec_bad = 1'b1;
            dec.alu_op  = ALU_OP_W'(alu_code(f3, (f3 == 3'b101) & i_instr[30]));
            dec.op2_sel = 1'b1; dec.rd_wren = 1'b1;
         end
         OPC_OP: begin
            dec.rd_wren = 1'b1;
            case (f7)
               7'b0000000: dec.alu_op = ALU_OP_W'(alu_code(f3, 1'b0));
               7'b0100000: begin
                  dec_bad    = (f3 != 3'b000) && (f3 != 3'b101);
                  dec.alu_op = ALU_OP_W'(alu_code(f3, 1'b1));
               end
               7'b0000001: begin
                  dec.alu_op = ALU_OP_W'(5'd10 + {2'b00, f3});
                  dec_mdu    = 1'b1;
               end
               default: dec_bad = 1'b1;
            endcase
         end
         OPC_FENCE: ;
         // Only ECALL and EBREAK are accepted in the SYSTEM space
         OPC_SYSTEM: dec_bad = (i_instr[31:7] != 25'h0) && (i_instr[31:7] != 25'h2000);
         default: dec_bad = 1'b1;
      endcase
      if (dec_bad) begin
         dec         = '0;
         dec.valid   = 1'b1;
         dec.illegal = 1'b1;
         dec_mdu     = 1'b0;
      end
   end

   assign accept = i_valid & ~i_stall & ~i_flush & (state_q == IDLE);

   // Next state, counter, bundle and done pulse
   always_comb begin : next_state
      state_d  = state_q;
      cnt_d    = cnt_q;
      bundle_d = bundle_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && dec_mdu) begin
               if (MDU_LATENCY > 1) begin
                  state_d = MDU_RUN;
                  cnt_d   = CNT_W'(MDU_LATENCY - 1);
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         MDU_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (i_flush)                 bundle_d = '0;
      else if (state_q == MDU_RUN) bundle_d = bundle_q;
      else if (i_stall)            bundle_d = bundle_q;
      else if (!i_valid)           bundle_d = '0;
      else                         bundle_d = dec;

      if (i_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bundle_q   <= '0;
         o_mdu_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bundle_q   <= bundle_d;
         o_mdu_done <= done_d;
      end
   end

   assign o_valid     = bundle_q.valid;
   assign o_illegal   = bundle_q.illegal;
   assign o_alu_op    = bundle_q.alu_op;
   assign o_op1_sel   = bundle_q.op1_sel;
   assign o_op2_sel   = bundle_q.op2_sel;
   assign o_wb_sel    = bundle_q.wb_sel;
   assign o_lsu_op    = bundle_q.lsu_op;
   assign o_rd_wren   = bundle_q.rd_wren;
   assign o_mem_rden  = bundle_q.mem_rden;
   assign o_mem_wren  = bundle_q.mem_wren;
   assign o_branch    = bundle_q.branch;
   assign o_jmp       = bundle_q.jmp;
   assign o_br_unsign = bundle_q.br_unsign;
   assign o_stall_req = (state_q == MDU_RUN);

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: directed test-plan steps followed by random traffic, each cycle
// compared against an occupancy-based reference model of the decode stage.
module tb_ctrl_decode_stage;

   localparam int unsigned ALU_OP_W = 5;
   localparam int unsigned LAT      = 4;
   localparam int unsigned CNT_W    = 6;

   logic                clk = 1'b0;
   logic                i_reset, i_valid, i_stall, i_flush;
   logic [31:0]         i_instr;
   logic                o_valid, o_illegal, o_op2_sel, o_rd_wren, o_mem_rden, o_mem_wren;
   logic                o_branch, o_jmp, o_br_unsign, o_stall_req, o_mdu_done;
   logic [ALU_OP_W-1:0] o_alu_op;
   logic [1:0]          o_op1_sel, o_wb_sel;
   logic [2:0]          o_lsu_op;

   always #5 clk = ~clk;

   ctrl_decode_stage #(.ALU_OP_W(ALU_OP_W), .MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_instr(i_instr), .i_valid(i_valid),
      .i_stall(i_stall), .i_flush(i_flush), .o_valid(o_valid), .o_illegal(o_illegal),
      .o_alu_op(o_alu_op), .o_op1_sel(o_op1_sel), .o_op2_sel(o_op2_sel),
      .o_wb_sel(o_wb_sel), .o_lsu_op(o_lsu_op), .o_rd_wren(o_rd_wren),
      .o_mem_rden(o_mem_rden), .o_mem_wren(o_mem_wren), .o_branch(o_branch),
      .o_jmp(o_jmp), .o_br_unsign(o_br_unsign), .o_stall_req(o_stall_req),
      .o_mdu_done(o_mdu_done)
   );

   typedef struct {
      int v, ill, alu, op1, op2, wb, lsu, rdw, rden, wren, br, jmp, uns, mdu;
   } exp_t;

   exp_t exp_b;
   int   occ;    // EX cycles still owed by the instruction in the slot, 0 when not an MDU op
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t zero_b();
      exp_t e = '{default: 0};
      return e;
   endfunction

   // Reference decode built from the instruction-set rules
   function automatic exp_t ref_decode(input logic [31:0] ins);
      exp_t       e = '{default: 0};
      int         alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      logic [6:0] opc = ins[6:0];
      logic [6:0] f7  = ins[31:25];
      int         f3  = int'(ins[14:12]);
      bit         ill = 1'b0;
      e.v = 1;
      if (opc == 7'h37) begin e.op1 = 2; e.op2 = 1; e.rdw = 1; end
      else if (opc == 7'h17) begin e.op1 = 1; e.op2 = 1; e.rdw = 1; end
      else if (opc == 7'h6f) begin e.op1 = 1; e.op2 = 1; e.wb = 2; e.jmp = 1; e.rdw = 1; end
      else if (opc == 7'h67) begin
         ill = (f3 != 0); e.op2 = 1; e.wb = 2; e.jmp = 1; e.rdw = 1;
      end else if (opc == 7'h63) begin
         ill = (f3 == 2 || f3 == 3);
         e.op1 = 1; e.op2 = 1; e.br = 1; e.uns = (f3 == 6 || f3 == 7) ? 1 : 0;
      end else if (opc == 7'h03) begin
         ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
         e.op2 = 1; e.wb = 1; e.rden = 1; e.rdw = 1; e.lsu = f3;
      end else if (opc == 7'h23) begin
         ill = (f3 > 2); e.op2 = 1; e.wren = 1; e.lsu = f3;
      end else if (opc == 7'h13) begin
         if ((f3 == 1 || f3 == 5) && !(f7 == 7'h00 || f7 == 7'h20)) ill = 1'b1;
         e.alu = alu_tab[f3] + ((f3 == 5 && ins[30]) ? 1 : 0);
         e.op2 = 1; e.rdw = 1;
      end else if (opc == 7'h33) begin
         e.rdw = 1;
         if (f7 == 7'h01) begin e.alu = 10 + f3; e.mdu = 1; end
         else if (f7 == 7'h00) e.alu = alu_tab[f3];
         else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) e.alu = alu_tab[f3] + 1;
         else ill = 1'b1;
      end else if (opc == 7'h0f) begin
      end else if (opc == 7'h73) begin
         ill = !(ins == 32'h0000_0073 || ins == 32'h0010_0073);
      end else ill = 1'b1;
      if (ill) begin
         e = '{default: 0};
         e.v = 1; e.ill = 1;
      end
      return e;
   endfunction

   // Slot behaviour on one clock edge, in terms of EX occupancy
   task automatic model_edge(input logic [31:0] ins, input bit v, input bit st, input bit fl);
      if (fl) begin exp_b = zero_b(); occ = 0; end
      else if (occ > 1) occ--;
      else if (st) occ = 0;
      else if (!v) begin exp_b = zero_b(); occ = 0; end
      else begin
         exp_b = ref_decode(ins);
         occ   = (exp_b.mdu != 0) ? int'(LAT) : 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"},   int'(o_valid),     exp_b.v);
      chk({tag, ".illegal"}, int'(o_illegal),   exp_b.ill);
      chk({tag, ".rd_wren"}, int'(o_rd_wren),   exp_b.rdw);
      chk({tag, ".rden"},    int'(o_mem_rden),  exp_b.rden);
      chk({tag, ".wren"},    int'(o_mem_wren),  exp_b.wren);
      chk({tag, ".branch"},  int'(o_branch),    exp_b.br);
      chk({tag, ".jmp"},     int'(o_jmp),       exp_b.jmp);
      if (exp_b.ill == 0) begin
         chk({tag, ".alu_op"},  int'(o_alu_op),    exp_b.alu);
         chk({tag, ".op1_sel"}, int'(o_op1_sel),   exp_b.op1);
         chk({tag, ".op2_sel"}, int'(o_op2_sel),   exp_b.op2);
         chk({tag, ".wb_sel"},  int'(o_wb_sel),    exp_b.wb);
         chk({tag, ".lsu_op"},  int'(o_lsu_op),    exp_b.lsu);
         chk({tag, ".unsign"},  int'(o_br_unsign), exp_b.uns);
      end
      chk({tag, ".stall_req"}, int'(o_stall_req), (occ > 1) ? 1 : 0);
      chk({tag, ".mdu_done"},  int'(o_mdu_done),  (occ == 1) ? 1 : 0);
   endtask

   task automatic cycle(input logic [31:0] ins, input bit v, input bit st, input bit fl,
                        input string tag);
      i_instr = ins; i_valid = v; i_stall = st; i_flush = fl;
      @(posedge clk);
      model_edge(ins, v, st, fl);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 i_reset = 1'b0;
      exp_b = zero_b(); occ = 0;
      #1 check_all(tag);
      chk({tag, ".all_out"}, int'({o_valid, o_illegal, o_alu_op, o_op1_sel, o_op2_sel,
          o_wb_sel, o_lsu_op, o_rd_wren, o_mem_rden, o_mem_wren, o_branch, o_jmp,
          o_br_unsign, o_stall_req, o_mdu_done}), 0);
      #3 i_reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r = $urandom;
      logic [6:0]  opcs[11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23,
                                7'h13, 7'h33, 7'h0f, 7'h73};
      logic [6:0]  f7s[4]   = '{7'h00, 7'h20, 7'h01, 7'h01};
      int          k        = int'($urandom_range(0, 13));
      if (k < 11) r[6:0] = opcs[k];
      if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0) r[31:25] = f7s[$urandom_range(0, 3)];
      if (r[6:0] == 7'h13 && $urandom_range(0, 1) != 0) r[31:25] = f7s[$urandom_range(0, 1)];
      if (r[6:0] == 7'h73 && $urandom_range(0, 1) != 0)
         r = ($urandom_range(0, 1) != 0) ? 32'h0010_0073 : 32'h0000_0073;
      return r;
   endfunction

   localparam logic [31:0] ADD  = 32'h0020_81B3;
   localparam logic [31:0] SUB  = 32'h4020_81B3;
   localparam logic [31:0] LUI  = 32'h1234_52B7;
   localparam logic [31:0] MUL  = 32'h0220_81B3;
   localparam logic [31:0] JALR = 32'h0001_00E7;
   localparam logic [31:0] LW   = 32'h0081_2203;

   initial begin
      i_reset = 1'b0; i_instr = '0; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      exp_b = zero_b(); occ = 0;
      #12;
      check_all("reset");
      i_reset = 1'b1;

      cycle(ADD, 1, 0, 0, "add");
      chk("add.alu_const", int'(o_alu_op), 0);
      chk("add.rd_wren_const", int'(o_rd_wren), 1);

      cycle(SUB, 1, 0, 0, "sub");
      chk("sub.alu_const", int'(o_alu_op), 1);
      cycle(LUI, 1, 0, 0, "lui");
      chk("lui.op1_const", int'(o_op1_sel), 2);
      chk("lui.valid_nobubble", int'(o_valid), 1);

      // mul with latency 4: three stall cycles, done in the fourth EX cycle
      cycle(MUL, 1, 0, 0, "mul1");
      chk("mul.alu_const", int'(o_alu_op), 10);
      chk("mul.stall1", int'(o_stall_req), 1);
      cycle(ADD, 1, 1, 0, "mul2");
      chk("mul.stall2", int'(o_stall_req), 1);
      cycle(ADD, 1, 0, 0, "mul3");
      chk("mul.stall3", int'(o_stall_req), 1);
      chk("mul.nodone3", int'(o_mdu_done), 0);
      cycle(ADD, 1, 0, 0, "mul4");
      chk("mul.stall4", int'(o_stall_req), 0);
      chk("mul.done4", int'(o_mdu_done), 1);
      chk("mul.held4", int'(o_alu_op), 10);
      cycle(ADD, 1, 0, 0, "after_mul");
      chk("after_mul.alu_const", int'(o_alu_op), 0);

      // mul aborted by a flush two cycles after acceptance
      cycle(MUL, 1, 0, 0, "mulf1");
      cycle(ADD, 1, 0, 0, "mulf2");
      cycle(ADD, 1, 0, 1, "mulf_flush");
      chk("flush.valid_const", int'(o_valid), 0);
      chk("flush.stall_const", int'(o_stall_req), 0);
      cycle(ADD, 0, 0, 0, "flush_post1");
      chk("flush.nodone", int'(o_mdu_done), 0);

      cycle(JALR, 1, 0, 0, "jalr");
      chk("jalr.wb_const", int'(o_wb_sel), 2);
      cycle(LW, 1, 1, 0, "jalr_hold");
      chk("jalr_hold.jmp_const", int'(o_jmp), 1);
      cycle(LW, 1, 0, 0, "lw");
      chk("lw.lsu_const", int'(o_lsu_op), 2);
      chk("lw.wb_const", int'(o_wb_sel), 1);

      cycle(32'hFFFF_FFFF, 1, 0, 0, "illegal");
      chk("illegal.flag_const", int'(o_illegal), 1);
      async_reset("reset_mid");

      // reset while an MDU op occupies EX
      cycle(MUL, 1, 0, 0, "mulr1");
      cycle(ADD, 1, 0, 0, "mulr2");
      async_reset("reset_mdu");
      cycle(ADD, 1, 0, 0, "post_reset");

      for (int n = 0; n < 600; n++) begin
         cycle(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
               $urandom_range(0, 15) == 0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
